// File: rtl/demux8_scheduler.sv
// Feeds an 8-channel byte demux: accepts one word, routes it round-robin or by destination, and holds it for the sink.
// Accept-to-valid is 1 cycle; in_ready drops while a word waits, and a word that is never accepted is dropped after TIMEOUT cycles.
module demux8_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_dest,
  input  logic       mode,
  input  logic [7:0] ch_en,
  output logic [2:0] sel,
  output logic [7:0] data_out,
  output logic [7:0] out_valid,
  input  logic [7:0] out_ready,
  output logic       drop,
  output logic [7:0] drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] data_q, data_d;
  logic [7:0] out_valid_q, out_valid_d;
  logic       drop_q, drop_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] last_q, last_d;

  logic       sel_ready;
  logic       hs;
  logic       tmo;
  logic       accept;
  logic [2:0] rr_ch;
  logic       rr_found;
  logic [2:0] rr_idx;
  logic [2:0] chosen;

  always_comb begin
    sel_ready = out_ready[sel_q];
    hs        = (state_q == SEND) && sel_ready;
    tmo       = (state_q == SEND) && (TIMEOUT != 0) && !sel_ready && (wait_q == TMO_LAST);
    in_ready  = rst_n && (|ch_en) && ((state_q == IDLE) || hs);
    accept    = in_valid && in_ready;

    // First enabled channel after last; i==8 wraps back onto last itself.
    rr_ch    = last_q;
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      rr_idx = last_q + 3'(i);
      if (!rr_found && ch_en[rr_idx]) begin
        rr_ch    = rr_idx;
        rr_found = 1'b1;
      end
    end
    chosen = mode ? in_dest : rr_ch;

    state_d    = state_q;
    sel_d      = sel_q;
    data_d     = data_q;
    wait_d     = wait_q;
    last_d     = last_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (state_q == SEND) begin
      if (!sel_ready) wait_d = wait_q + 8'd1;
      if (hs) state_d = IDLE;
      if (tmo) begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end
    end

    if (accept) begin
      data_d = in_data;
      sel_d  = chosen;
      wait_d = 8'd0;
      if (!mode) last_d = rr_ch;
      // A directed word to a disabled channel is taken off the port and discarded.
      if (ch_en[chosen]) begin
        state_d = SEND;
      end else begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end
    end

    if (drop_d && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    out_valid_d = (state_d == SEND) ? (8'd1 << sel_d) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      data_q      <= 8'd0;
      out_valid_q <= 8'd0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= 8'd0;
      wait_q      <= 8'd0;
      last_q      <= 3'd7;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
      wait_q      <= wait_d;
      last_q      <= last_d;
    end
  end

  assign sel       = sel_q;
  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign drop      = drop_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux8_scheduler.sv
// Bench for demux8_scheduler: vector table plus scoreboard of expected deliveries.
module tb_demux8_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       mode;
  logic [7:0] ch_en;
  logic [2:0] sel;
  logic [7:0] data_out;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic       drop;
  logic [7:0] drop_cnt;

  demux8_scheduler #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .mode(mode), .ch_en(ch_en),
    .sel(sel), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] en;
    logic [2:0] dst;
    logic [7:0] d;
    logic [2:0] ch;
    bit         b2b;
  } vec_t;

  vec_t        tbl[14];
  logic [10:0] sb_q[$];
  logic [10:0] mon_e;
  int          nvec = 0;
  int          nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic m, input logic [7:0] en, input logic [2:0] dst,
                      input logic [7:0] d, input bit push, input logic [2:0] exp_ch,
                      output int waited);
    mode = m; ch_en = en; in_dest = dst; in_data = d; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready stayed 0 for data %0h", d);
    end else if (push) begin
      sb_q.push_back({exp_ch, d});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Every completed handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (out_valid & out_ready) != 8'd0) begin
      if (sb_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_delivery: sel %0d data %0h", sel, data_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("deliver_sel", 32'(sel), 32'(mon_e[10:8]));
        check("deliver_data", 32'(data_out), 32'(mon_e[7:0]));
        check("deliver_onehot", 32'(out_valid), 32'(8'd1 << mon_e[10:8]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    int exp_cnt;

    for (int i = 0; i < 9; i++) begin
      tbl[i].m = 1'b0; tbl[i].en = 8'hFF; tbl[i].dst = 3'd0;
      tbl[i].d = 8'h10 + 8'(i); tbl[i].ch = 3'(i % 8); tbl[i].b2b = 1'b1;
    end
    tbl[9]  = '{m: 1'b0, en: 8'h24, dst: 3'd0, d: 8'h31, ch: 3'd2, b2b: 1'b1};
    tbl[10] = '{m: 1'b0, en: 8'h24, dst: 3'd0, d: 8'h32, ch: 3'd5, b2b: 1'b1};
    tbl[11] = '{m: 1'b0, en: 8'h24, dst: 3'd0, d: 8'h33, ch: 3'd2, b2b: 1'b1};
    tbl[12] = '{m: 1'b1, en: 8'hFF, dst: 3'd3, d: 8'h55, ch: 3'd3, b2b: 1'b1};
    tbl[13] = '{m: 1'b0, en: 8'hFF, dst: 3'd0, d: 8'h66, ch: 3'd3, b2b: 1'b1};

    // Reset with in_valid held high
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_dest = 3'd0;
    mode = 1'b0; ch_en = 8'hFF; out_ready = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table: round-robin, masked round-robin, directed, round-robin after directed
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].m, tbl[i].en, tbl[i].dst, tbl[i].d, 1'b1, tbl[i].ch, w);
      if (tbl[i].b2b) check($sformatf("b2b_wait_%0d", i), 32'(w), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("table_drained", 32'(sb_q.size()), 32'd0);
    check("table_idle_valid", 32'(out_valid), 32'd0);
    mode = 1'b0; ch_en = 8'h00; #1;
    check("no_en_rr_ready", 32'(in_ready), 32'd0);
    mode = 1'b1; #1;
    check("no_en_dir_ready", 32'(in_ready), 32'd0);

    // Directed word held off by channel 6 for three cycles
    out_ready = 8'hBF;
    send(1'b1, 8'hFF, 3'd6, 8'hAA, 1'b1, 3'd6, w);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid == 8'h40) cnt++;
      @(posedge clk); #1;
    end
    out_ready = 8'hFF;
    if (out_valid == 8'h40) cnt++;
    @(posedge clk); #1;
    check("dir_valid_cycles", 32'(cnt), 32'd4);
    check("dir_valid_clear", 32'(out_valid), 32'd0);
    check("dir_drained", 32'(sb_q.size()), 32'd0);

    // Directed word to a disabled channel is discarded
    send(1'b1, 8'hBF, 3'd6, 8'h11, 1'b0, 3'd6, w);
    check("dis_drop", 32'(drop), 32'd1);
    check("dis_drop_cnt", 32'(drop_cnt), 32'd1);
    check("dis_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("dis_drop_end", 32'(drop), 32'd0);
    check("dis_still_idle", 32'(out_valid), 32'd0);
    exp_cnt = 1;

    // Timeouts with every sink stalled, until the counter saturates
    out_ready = 8'h00;
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 8'hFF, 3'd0, 8'(i), 1'b0, 3'd0, w);
      cnt = 0;
      while (out_valid != 8'd0 && cnt < 100) begin
        cnt++;
        @(posedge clk); #1;
      end
      if (exp_cnt < 255) exp_cnt++;
      if (i == 0) begin
        check("tmo_valid_cycles", 32'(cnt), 32'd15);
        check("tmo_drop", 32'(drop), 32'd1);
        @(posedge clk); #1;
        check("tmo_drop_end", 32'(drop), 32'd0);
      end else if (cnt != 15) begin
        check($sformatf("tmo_valid_cycles_%0d", i), 32'(cnt), 32'd15);
      end
      if (i < 3 || i > 250) check($sformatf("tmo_drop_cnt_%0d", i), 32'(drop_cnt), 32'(exp_cnt));
    end
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // Reset while a word waits on channel 3
    send(1'b1, 8'hFF, 3'd3, 8'h77, 1'b0, 3'd3, w);
    @(negedge clk);
    check("mid_send_valid", 32'(out_valid), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("async_rst_drop", 32'(drop), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 8'hFF;
    send(1'b0, 8'hFF, 3'd5, 8'h5A, 1'b1, 3'd0, w);
    check("post_rst_sel", 32'(sel), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("final_drained", 32'(sb_q.size()), 32'd0);
    check("final_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/demux8_scheduler.md
# demux8_scheduler

Sequencing controller for the 8-bit, 8-channel demultiplexer (`demux8bit_8channel`). It accepts one byte at a time over a valid/ready input port and drives the demux `sel` and `data_in` inputs. It then presents the routed byte on the chosen channel with a per-channel valid/ready handshake. Channels are chosen either round-robin over an enable mask or directly by a destination field. A word that its channel never accepts is dropped after a timeout, so one stalled sink cannot block the other channels.

## Interface
Parameters:
- `TIMEOUT`, default 15: number of cycles a word may wait for `out_ready`. Legal range 0..255; 0 disables the timeout.

Ports:
- `clk`, input, 1: the block's only clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: block can accept a word this cycle.
- `in_data`, input, 8: upstream byte.
- `in_dest`, input, 3: destination channel. Used only when `mode`=1.
- `mode`, input, 1: 0 selects round-robin, 1 selects directed.
- `ch_en`, input, 8: per-channel enable mask.
- `sel`, output, 3: select code driven to the demux `sel`.
- `data_out`, output, 8: byte driven to the demux `data_in`.
- `out_valid`, output, 8: one-hot valid. Bit n qualifies demux `out<n>`.
- `out_ready`, input, 8: per-channel sink ready.
- `drop`, output, 1: one-cycle pulse when a word is discarded.
- `drop_cnt`, output, 8: saturating count of dropped words.

## Operation
- There are two states, IDLE and SEND. The block holds at most one word.
- **Reset values:** state IDLE, `sel`=0, `data_out`=0, `out_valid`=0, `drop`=0, `drop_cnt`=0, wait counter 0, round-robin pointer `last`=7.
- **`in_ready` is combinational.** `in_ready` = `rst_n` & (|`ch_en`) & (state==IDLE | handshake completing this cycle).
  - If `ch_en`=0, `in_ready` stays 0 in round-robin mode and in directed mode alike.
- **Accept condition:** a word is accepted when `in_valid` & `in_ready`. On accept, `data_out` is loaded with `in_data`, `sel` is loaded with the chosen channel, and the wait counter is cleared.
- **Round-robin channel choice (`mode`=0):**
  - The chosen channel is the first enabled channel in the order `last`+1, `last`+2, …, `last`+8, all mod 8.
  - If `last` is the only enabled channel, `last` is reused.
  - On accept, `last` is set to the chosen channel.
- **Directed channel choice (`mode`=1):**
  - The chosen channel is `in_dest`, and `last` is unchanged.
  - If `ch_en[in_dest]`=0, the word is still accepted but is discarded at once. `drop` pulses on the next cycle, `drop_cnt` increments, and the state stays IDLE with `out_valid`=0.
- **SEND state:** `out_valid` = one-hot(`sel`). `sel` and `data_out` are held stable.
- **Handshake completion:** when `out_valid[sel]` & `out_ready[sel]`, the word is delivered.
  - If a new word is accepted in the same cycle, the block stays in SEND with the new channel.
  - Otherwise it returns to IDLE and `out_valid` becomes 0.
  - `out_ready` bits for channels other than `sel` are ignored.
- **Timeout:** the wait counter increments on each SEND cycle in which `out_ready[sel]` is 0.
  - If `TIMEOUT`≠0, the counter equals `TIMEOUT`−1, and `out_ready[sel]`=0, then at that edge the word is dropped: state goes to IDLE, `out_valid` goes to 0, `drop` pulses, and `drop_cnt` increments.
  - No new word is accepted in the timeout cycle.
- **`drop_cnt` saturates at 255.**
- **`ch_en` changes:** changing `ch_en` during SEND does not abort the pending word. The mask is sampled only at accept.

## Timing
- Accept-to-valid latency is 1 cycle: `out_valid` is asserted in the cycle after the accepting edge.
- Sustained throughput is one word per cycle when sinks hold ready high. This works because a completing handshake and a new accept can occur in the same cycle.
- `sel`, `data_out` and `out_valid` change only on clock edges, which keeps the demux outputs glitch-free relative to `clk`.
- On a timeout, `out_valid` is high for exactly `TIMEOUT` cycles. `drop` is high in the first cycle after the drop edge.
- When `rst_n` is asserted mid-SEND, all outputs go to their reset values immediately. No `drop` pulse is generated and `drop_cnt` is cleared.
- There is no combinational path from `in_data` or `in_dest` to any output.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `sel`=0, `drop_cnt`=0. After release with `ch_en`=FF → `in_ready`=1.
- **Round-robin, all channels ready:** `ch_en`=FF, `out_ready`=FF, back-to-back words 0x10..0x17 → `sel` steps 0..7, one word per cycle; `out_valid`=01,02,…,80; `data_out` matches each word; the 9th word goes to channel 0.
- **Masked round-robin:** `ch_en`=0x24, three words → channels 2, 5, 2. Then `ch_en`=0 → `in_ready`=0.
- **Directed mode:** `mode`=1, `in_dest`=6, data 0xAA, `out_ready[6]` low for 3 cycles → `out_valid`=0x40 for 4 cycles and then clears. Repeat with `ch_en[6]`=0 → `drop` pulse, `drop_cnt`=1, `out_valid` stays 0.
- **Timeout:** `TIMEOUT`=15, `out_ready`=0 → `out_valid` is high for 15 cycles, then `drop`=1 for one cycle and `drop_cnt` increments. 300 timeouts → `drop_cnt`=255.
- **Reset mid-SEND:** assert `rst_n`=0 while `out_valid`=0x08 → `out_valid`=0 asynchronously. After release, the first round-robin word goes to channel 0.
